mult_arbiter: RTL and testbench

- Shares one sequential 32x32 signed multiplier (start/done handshake, ~33-cycle latency) between N requesters, e.g. hash-schedule and nonce-update engines on the FPGA miner.
- Round-robin grant, operand latching, start sequencing, result return to the winning requester, and a watchdog timeout with multiplier abort.
- Sits between requesters and the multiplier instance; no other block drives the multiplier.

---
 rtl/mult_arb_pkg.sv | 24 ++
 rtl/mult_arbiter_rr_picker.sv | 36 +++
 rtl/mult_arbiter.sv | 155 +++++++++++++++
 tb/tb_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM states, data width
// and a constant-function log2 used to size pointers and counters.
package mult_arb_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Returns ceil(log2(value)), never less than 1 so a pointer is always at least one bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) res = i + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the first set request at or
// above ptr (wrapping modulo N_REQ) wins.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest set request is written last.
  always_comb begin : pick
    int pos;
    grant = {N_REQ{1'b0}};
    idx   = {PW{1'b0}};
    any   = 1'b0;
    pos   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (req[pos]) begin
        grant      = {N_REQ{1'b0}};
        grant[pos] = 1'b1;
        idx        = PW'(pos);
        any        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential signed multiplier among N_REQ requesters: round-robin
// grant, operand latching, start/done sequencing, result return and watchdog abort.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 40,
  parameter int DONE_MASK = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [W*N_REQ-1:0] req_mc,
  input  logic [W*N_REQ-1:0] req_mp,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_prod,
  output logic               rsp_overflow,
  output logic               rsp_error,
  output logic               mul_start,
  output logic               mul_reset,
  output logic [W-1:0]       mul_mc,
  output logic [W-1:0]       mul_mp,
  input  logic [W-1:0]       mul_prod,
  input  logic               mul_overflow,
  input  logic               mul_done,
  output logic               busy
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e           state_r, next_state_s;
  logic [PW-1:0]    rr_ptr_r, owner_r, pick_idx_s;
  logic [N_REQ-1:0] pick_grant_s;
  logic             pick_any_s, accept_s, done_ok_s, timeout_s;
  logic [CW-1:0]    wait_cnt_r;
  logic [W-1:0]     mc_r, mp_r, prod_r;
  logic             ovf_r, err_r;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // A done level is trusted only after the mask window, since it may still be stale from the last job.
  assign accept_s  = (state_r == IDLE) && pick_any_s && !reset;
  assign done_ok_s = (state_r == WAIT) && mul_done && (wait_cnt_r >= CW'(DONE_MASK));
  assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = START;
        else          next_state_s = IDLE;
      end
      START: next_state_s = WAIT;
      WAIT: begin
        if (done_ok_s || timeout_s) next_state_s = RESP;
        else                        next_state_s = WAIT;
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand latch, owner, wait counter, captured result and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r   <= {PW{1'b0}};
      owner_r    <= {PW{1'b0}};
      wait_cnt_r <= {CW{1'b0}};
      mc_r       <= {W{1'b0}};
      mp_r       <= {W{1'b0}};
      prod_r     <= {W{1'b0}};
      ovf_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mc_r    <= req_mc[pick_idx_s*W +: W];
            mp_r    <= req_mp[pick_idx_s*W +: W];
            owner_r <= pick_idx_s;
          end
        end
        START: begin
          wait_cnt_r <= {CW{1'b0}};
          err_r      <= 1'b0;
        end
        WAIT: begin
          wait_cnt_r <= wait_cnt_r + CNT_ONE;
          if (done_ok_s) begin
            prod_r <= mul_prod;
            ovf_r  <= mul_overflow;
            err_r  <= 1'b0;
          end else if (timeout_s) begin
            prod_r <= {W{1'b0}};
            ovf_r  <= 1'b0;
            err_r  <= 1'b1;
          end
        end
        RESP: begin
          rr_ptr_r <= (owner_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : owner_r + {{(PW-1){1'b0}}, 1'b1};
        end
        default: begin
          rr_ptr_r <= rr_ptr_r;
        end
      endcase
    end
  end

  // Output decode from the registered state and captured data.
  always_comb begin
    req_ready    = {N_REQ{1'b0}};
    rsp_valid    = {N_REQ{1'b0}};
    rsp_prod     = {W{1'b0}};
    rsp_overflow = 1'b0;
    rsp_error    = 1'b0;
    mul_start    = 1'b0;
    mul_reset    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) req_ready = pick_grant_s;
        else          req_ready = {N_REQ{1'b0}};
      end
      START: mul_start = 1'b1;
      WAIT:  mul_reset = timeout_s && !done_ok_s && !reset;
      RESP: begin
        rsp_valid[owner_r] = 1'b1;
        rsp_prod           = prod_r;
        rsp_overflow       = ovf_r;
        rsp_error          = err_r;
      end
      default: mul_start = 1'b0;
    endcase
  end

  assign busy   = (state_r != IDLE);
  assign mul_mc = mc_r;
  assign mul_mp = mp_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural sequential multiplier that
// can run normally, present a stale done after start, or never finish.
module tb_mult_arbiter;

  localparam int N         = 4;
  localparam int W         = 32;
  localparam int TIMEOUT   = 40;
  localparam int DONE_MASK = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [W*N-1:0]     req_mc, req_mp;
  logic [N-1:0]       req_ready, rsp_valid;
  logic [W-1:0]       rsp_prod;
  logic               rsp_overflow, rsp_error;
  logic               mul_start, mul_reset;
  logic [W-1:0]       mul_mc, mul_mp;
  logic [W-1:0]       mul_prod;
  logic               mul_overflow, mul_done;
  logic               busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // multiplier model controls: mode 0 normal, 1 stale done after start, 2 never done
  int     lat_v, mode_v;
  int     m_cnt, stale_cnt;
  longint m_prod;

  int fair_ord  [6] = '{0, 2, 3, 0, 2, 3};
  int fair_prod [6] = '{10, 30, 40, 10, 30, 40};

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT), .DONE_MASK(DONE_MASK)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_mc       (req_mc),
    .req_mp       (req_mp),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_prod     (rsp_prod),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error),
    .mul_start    (mul_start),
    .mul_reset    (mul_reset),
    .mul_mc       (mul_mc),
    .mul_mp       (mul_mp),
    .mul_prod     (mul_prod),
    .mul_overflow (mul_overflow),
    .mul_done     (mul_done),
    .busy         (busy)
  );

  always @(posedge clk) begin
    if (reset || mul_reset) begin
      m_cnt        <= 0;
      stale_cnt    <= 0;
      mul_done     <= 1'b0;
      mul_prod     <= 32'h0;
      mul_overflow <= 1'b0;
    end else if (mul_start) begin
      m_prod <= longint'($signed(mul_mc)) * longint'($signed(mul_mp));
      m_cnt  <= (mode_v == 2) ? 0 : lat_v;
      if (mode_v == 1) begin
        mul_done  <= 1'b1;
        mul_prod  <= 32'hDEADBEEF;
        stale_cnt <= 2;
      end else begin
        mul_done <= 1'b0;
      end
    end else begin
      if (stale_cnt != 0) begin
        stale_cnt <= stale_cnt - 1;
        if (stale_cnt == 1) mul_done <= 1'b0;
      end
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          mul_done     <= 1'b1;
          mul_prod     <= m_prod[31:0];
          mul_overflow <= (m_prod > 64'sd2147483647) || (m_prod < -64'sd2147483648);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // one complete operation from an idle arbiter; exp_lat <= 0 skips the latency check
  task automatic run_op(input string tag, input int port, input logic [31:0] mc,
                        input logic [31:0] mp, input logic [31:0] exp_prod,
                        input logic exp_ovf, input int exp_lat);
    logic [N-1:0] oh;
    int n;
    oh = 4'b0001 << port;
    @(negedge clk);
    req_valid[port]      = 1'b1;
    req_mc[port*W +: W]  = mc;
    req_mp[port*W +: W]  = mp;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid[port]      = 1'b0;
    req_mc[port*W +: W]  = ~mc;
    req_mp[port*W +: W]  = ~mp;
    chk({tag, "_start"}, 64'(mul_start), 64'h1);
    chk({tag, "_mc"}, 64'(mul_mc), 64'(mc));
    chk({tag, "_mp"}, 64'(mul_mp), 64'(mp));
    n = 1;
    while (rsp_valid == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, "_prod"}, 64'(rsp_prod), 64'(exp_prod));
    chk({tag, "_ovf"}, 64'(rsp_overflow), 64'(exp_ovf));
    chk({tag, "_err"}, 64'(rsp_error), 64'h0);
    if (exp_lat > 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    @(negedge clk);
    chk({tag, "_rsp_clear"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_idle"}, 64'(busy), 64'h0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_mc    = {(W*N){1'b0}};
    req_mp    = {(W*N){1'b0}};
    lat_v     = 33;
    mode_v    = 0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp", 64'(rsp_valid), 64'h0);
    chk("rst_start", 64'(mul_start), 64'h0);
    chk("rst_mulrst", 64'(mul_reset), 64'h0);
    chk("rst_mc", 64'(mul_mc), 64'h0);

    run_op("single", 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 0);

    lat_v = 1;
    run_op("minlat", 3, 32'd5, 32'd5, 32'd25, 1'b0, DONE_MASK + 3);

    lat_v = 33;
    run_op("ovf", 1, 32'h40000000, 32'd4, 32'h00000000, 1'b1, 0);

    // ports 0, 2, 3 hold requests; grants must rotate and skip port 1
    do_reset();
    lat_v = 1;
    @(negedge clk);
    req_valid = 4'b1101;
    req_mc[0*W +: W] = 32'd1;
    req_mc[2*W +: W] = 32'd3;
    req_mc[3*W +: W] = 32'd4;
    req_mp = {4{32'd10}};
    #1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (req_ready == 4'b0000 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("fair_grant", 64'(req_ready), 64'(4'b0001 << fair_ord[i]));
      n = 0;
      while (rsp_valid == 4'b0000 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("fair_rsp", 64'(rsp_valid), 64'(4'b0001 << fair_ord[i]));
      chk("fair_prod", 64'(rsp_prod), 64'(fair_prod[i]));
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("fair_idle", 64'(busy), 64'h0);

    lat_v  = 33;
    mode_v = 1;
    run_op("stale", 2, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFE2, 1'b0, 0);

    // watchdog: the multiplier never finishes
    mode_v = 2;
    @(negedge clk);
    req_valid[3] = 1'b1;
    req_mc[3*W +: W] = 32'd3;
    req_mp[3*W +: W] = 32'd3;
    #1;
    chk("to_ready", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid[3] = 1'b0;
    chk("to_start", 64'(mul_start), 64'h1);
    n = 0;
    while (mul_reset == 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycle", 64'(n), 64'(TIMEOUT));
    chk("to_no_rsp_yet", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    chk("to_rsp", 64'(rsp_valid), 64'h8);
    chk("to_err", 64'(rsp_error), 64'h1);
    chk("to_prod", 64'(rsp_prod), 64'h0);
    chk("to_mulrst_pulse", 64'(mul_reset), 64'h0);
    @(negedge clk);
    mode_v = 0;
    lat_v  = 33;
    run_op("after_to", 0, 32'd2, 32'd3, 32'd6, 1'b0, 0);

    // reset while waiting at wait_cnt = 10, pointer currently 1
    mode_v = 2;
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_mc[2*W +: W] = 32'd9;
    req_mp[2*W +: W] = 32'd9;
    #1;
    chk("rw_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (11) @(negedge clk);
    chk("rw_busy_before", 64'(busy), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_busy", 64'(busy), 64'h0);
    chk("rw_start", 64'(mul_start), 64'h0);
    chk("rw_mulrst", 64'(mul_reset), 64'h0);
    chk("rw_rsp", 64'(rsp_valid), 64'h0);
    chk("rw_mc", 64'(mul_mc), 64'h0);
    reset  = 1'b0;
    mode_v = 0;
    lat_v  = 1;
    req_valid = 4'b1001;
    req_mc[0*W +: W] = 32'hFFFFFFFF;
    req_mp[0*W +: W] = 32'hFFFFFFFF;
    req_mc[3*W +: W] = 32'd7;
    req_mp[3*W +: W] = 32'd7;
    #1;
    chk("rw_rr_zero", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("rw_new_mc", 64'(mul_mc), 64'hFFFFFFFF);
    n = 0;
    while (rsp_valid == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rw_new_rsp", 64'(rsp_valid), 64'h1);
    chk("rw_new_prod", 64'(rsp_prod), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
